// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, ALU functions, condition codes, status codes.
package y86_pkg;

  localparam int unsigned WORD = 64;
  localparam logic [3:0] RNONE = 4'hF;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fun_e;

  // Branch / cmov condition selectors (ifun)
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_ADR = 2'd2,
    STAT_INS = 2'd3
  } stat_e;

  localparam logic [WORD-1:0] PLUS8  = 64'd8;
  localparam logic [WORD-1:0] MINUS8 = ~64'd7;

  localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/y86_alu.sv
// Combinational Y86-64 ALU producing result and ZF/SF/OF.
module y86_alu
  import y86_pkg::*;
(
  input  logic [WORD-1:0] a,
  input  logic [WORD-1:0] b,
  input  logic [1:0]      fun,
  output logic [WORD-1:0] result,
  output logic            zf,
  output logic            sf,
  output logic            of
);

  // Operation select and flag derivation; B is the left operand (B-A for sub).
  always_comb begin
    result = b + a;
    of     = 1'b0;
    unique case (fun)
      ALU_ADD: begin
        result = b + a;
        of     = (a[WORD-1] == b[WORD-1]) && (result[WORD-1] != a[WORD-1]);
      end
      ALU_SUB: begin
        result = b - a;
        of     = (a[WORD-1] != b[WORD-1]) && (result[WORD-1] != b[WORD-1]);
      end
      ALU_AND: result = b & a;
      ALU_XOR: result = b ^ a;
      default: ;
    endcase
    zf = (result == '0);
    sf = result[WORD-1];
  end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand muxes, ALU, condition codes, cnd evaluation and E->M register.
module execute_stage
  import y86_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [1:0]      in_stat,
  input  logic [3:0]      in_icode,
  input  logic [3:0]      in_ifun,
  input  logic [WORD-1:0] in_valC,
  input  logic [WORD-1:0] in_valA,
  input  logic [WORD-1:0] in_valB,
  input  logic [3:0]      in_dstE,
  input  logic [3:0]      in_dstM,
  input  logic            stall,
  input  logic            bubble,
  input  logic            m_exc,
  output logic            out_valid,
  output logic [1:0]      out_stat,
  output logic [3:0]      out_icode,
  output logic            out_cnd,
  output logic [WORD-1:0] out_valE,
  output logic [WORD-1:0] out_valA,
  output logic [3:0]      out_dstE,
  output logic [3:0]      out_dstM,
  output logic [2:0]      cc
);

  logic [WORD-1:0] alu_a;
  logic [WORD-1:0] alu_b;
  logic [1:0]      alu_fun;
  logic [WORD-1:0] alu_result;
  logic            alu_zf;
  logic            alu_sf;
  logic            alu_of;
  logic [2:0]      cc_q;
  logic            cnd;
  logic            cc_en;
  logic [3:0]      dste_gated;

  // Operand selection by instruction class.
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    unique case (in_icode)
      I_RRMOVQ, I_OPQ:              alu_a = in_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = in_valC;
      I_CALL, I_PUSHQ:              alu_a = MINUS8;
      I_RET, I_POPQ:                alu_a = PLUS8;
      default:                      alu_a = '0;
    endcase
    unique case (in_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = in_valB;
      default:                                                   alu_b = '0;
    endcase
    alu_fun = (in_icode == I_OPQ) ? in_ifun[1:0] : ALU_ADD;
  end

  y86_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .fun    (alu_fun),
    .result (alu_result),
    .zf     (alu_zf),
    .sf     (alu_sf),
    .of     (alu_of)
  );

  // Condition from the CC value held before this edge's update; cc_q = {ZF,SF,OF}.
  always_comb begin
    cnd = 1'b0;
    unique case (in_ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = (cc_q[1] ^ cc_q[0]) | cc_q[2];
      C_L:     cnd = cc_q[1] ^ cc_q[0];
      C_E:     cnd = cc_q[2];
      C_NE:    cnd = ~cc_q[2];
      C_GE:    cnd = ~(cc_q[1] ^ cc_q[0]);
      C_G:     cnd = ~(cc_q[1] ^ cc_q[0]) & ~cc_q[2];
      default: cnd = 1'b0;
    endcase
    dste_gated = ((in_icode == I_RRMOVQ) && !cnd) ? RNONE : in_dstE;
    cc_en = in_valid && (in_icode == I_OPQ) && !stall && !bubble && !m_exc
            && (in_stat == STAT_AOK);
  end

  // Condition-code register, written only by a clean, unstalled OPq.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_q <= CC_RESET;
    end else if (cc_en) begin
      cc_q <= {alu_zf, alu_sf, alu_of};
    end
  end

  assign cc = cc_q;

  // E->M pipeline register: stall holds, bubble or invalid input loads a nop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_stat  <= STAT_AOK;
      out_icode <= I_NOP;
      out_cnd   <= 1'b0;
      out_valE  <= '0;
      out_valA  <= '0;
      out_dstE  <= RNONE;
      out_dstM  <= RNONE;
    end else if (stall) begin
      // hold
    end else if (bubble || !in_valid) begin
      out_valid <= 1'b0;
      out_stat  <= STAT_AOK;
      out_icode <= I_NOP;
      out_cnd   <= 1'b0;
      out_valE  <= '0;
      out_valA  <= '0;
      out_dstE  <= RNONE;
      out_dstM  <= RNONE;
    end else begin
      out_valid <= 1'b1;
      out_stat  <= in_stat;
      out_icode <= in_icode;
      out_cnd   <= cnd;
      out_valE  <= alu_result;
      out_valA  <= in_valA;
      out_dstE  <= dste_gated;
      out_dstM  <= in_dstM;
    end
  end

endmodule
